audio_filter: RTL

- Downstream audio stage between the gameandwatch core's 1-bit `sound` output and the platform AUDIO_L/AUDIO_R ports.
- Replaces the raw bit-replication with three steps:
  - box-filter decimation of the 1-bit stream to a fixed sample rate,
  - a one-pole IIR low-pass that removes buzzer harshness,
  - a selectable volume attenuation.
- Produces 16-bit unsigned samples with a one-cycle valid strobe. Output is intended for AUDIO_S=0.

---
 rtl/audio_filter.sv | 101 ++++++++++
 1 files changed

// File: rtl/audio_filter.sv
// Audio post-processing for the 1-bit buzzer: box-filter decimation, one-pole IIR
// low-pass and volume attenuation, producing 16-bit unsigned samples with a valid strobe.
module audio_filter #(
  parameter int unsigned DECIM = 2048,
  parameter int unsigned K     = 3
) (
  input  logic        clk_sys_131_072,
  input  logic        reset,
  input  logic        sound,
  input  logic        filter_en,
  input  logic [1:0]  volume,
  output logic [15:0] sample,
  output logic        sample_valid
);

  localparam int unsigned CNT_W = $clog2(DECIM);
  localparam int unsigned ACC_W = CNT_W + 1;
  localparam int unsigned X_SH  = 16 - CNT_W;
  localparam int unsigned Y_W   = 16 + K;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] box_c;
  logic             terminal_c;
  logic [16:0]      x_wide_c;
  logic [15:0]      x;
  logic             x_valid;
  logic [Y_W-1:0]   y_scaled;
  logic [Y_W-1:0]   y_next_c;
  logic [15:0]      y_c;
  logic             y_valid;

  assign terminal_c = (cnt == CNT_W'(DECIM - 1));
  assign box_c      = acc + ACC_W'(sound);
  assign x_wide_c   = 17'(box_c) << X_SH;

  // Intermediate wraparound in Y_W bits cancels out: the true result always fits.
  always_comb begin
    y_next_c = Y_W'(x) << K;
    if (filter_en) begin
      y_next_c = y_scaled + Y_W'(x) - (y_scaled >> K);
    end
  end

  assign y_c = 16'(y_scaled >> K);

  // Window counter and box accumulator; the accumulator restarts clean every window.
  always_ff @(posedge clk_sys_131_072 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (terminal_c) begin
        acc <= '0;
      end else begin
        acc <= box_c;
      end
    end
  end

  // Stage 1: scale the window count to 16 bits, saturating a full-high window.
  always_ff @(posedge clk_sys_131_072 or posedge reset) begin
    if (reset) begin
      x       <= '0;
      x_valid <= 1'b0;
    end else begin
      x_valid <= terminal_c;
      if (terminal_c) begin
        x <= (x_wide_c > 17'd65535) ? 16'hFFFF : x_wide_c[15:0];
      end
    end
  end

  // Stage 2: IIR state, kept scaled by 2^K; bypass keeps it tracking x for a stepless handover.
  always_ff @(posedge clk_sys_131_072 or posedge reset) begin
    if (reset) begin
      y_scaled <= '0;
      y_valid  <= 1'b0;
    end else begin
      y_valid <= x_valid;
      if (x_valid) begin
        y_scaled <= y_next_c;
      end
    end
  end

  // Stage 3: volume attenuation and output strobe.
  always_ff @(posedge clk_sys_131_072 or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= y_valid;
      if (y_valid) begin
        sample <= y_c >> volume;
      end
    end
  end

endmodule
